// File: rtl/doodle_pkg.sv
// rtl/doodle_pkg.sv - shared state encoding, physics defaults and screen bounds
package doodle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RISING  = 2'd1,
    ST_FALLING = 2'd2,
    ST_DEAD    = 2'd3
  } state_t;

  localparam int DEF_START_Y     = 400;
  localparam int DEF_SCROLL_LINE = 200;
  localparam int DEF_BOTTOM_Y    = 514;
  localparam int DEF_JUMP_V      = 12;
  localparam int DEF_GRAVITY     = 1;
  localparam int DEF_MAX_FALL    = 10;

  localparam int SCREEN_TOP    = 35;
  localparam int SCREEN_BOTTOM = 514;
  localparam int SCREEN_LEFT   = 144;
  localparam int SCREEN_RIGHT  = 783;

endpackage

// File: rtl/frame_contact_latch.sv
// rtl/frame_contact_latch.sv - remembers any platform contact seen during the current frame
module frame_contact_latch (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic contact,
  output logic latched
);

  // The tick consumes the latch, so a contact only counts for one frame update.
  always_ff @(posedge clk) begin
    if (rst || frame_tick) begin
      latched <= 1'b0;
    end else if (contact) begin
      latched <= 1'b1;
    end
  end

endmodule

// File: rtl/doodle_physics.sv
// rtl/doodle_physics.sv - per-frame vertical motion, landing, scrolling and scoring of the doodle
module doodle_physics
  import doodle_pkg::*;
#(
  parameter int START_Y     = DEF_START_Y,
  parameter int SCROLL_LINE = DEF_SCROLL_LINE,
  parameter int BOTTOM_Y    = DEF_BOTTOM_Y,
  parameter int JUMP_V      = DEF_JUMP_V,
  parameter int GRAVITY     = DEF_GRAVITY,
  parameter int MAX_FALL    = DEF_MAX_FALL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        contact,
  output logic [9:0]  doodle_y,
  output logic [9:0]  v_counter,
  output logic [15:0] score,
  output logic        game_over,
  output logic [1:0]  state
);

  localparam logic [9:0]         START_Y10   = 10'(START_Y);
  localparam logic [9:0]         SCROLL_Y10  = 10'(SCROLL_LINE);
  localparam logic [9:0]         BOTTOM_Y10  = 10'(BOTTOM_Y);
  localparam logic signed [10:0] SCROLL_S    = 11'(SCROLL_LINE);
  localparam logic signed [10:0] BOTTOM_S    = 11'(BOTTOM_Y);
  localparam logic signed [5:0]  LAUNCH_VEL  = -6'(JUMP_V);
  localparam logic signed [6:0]  MAX_FALL_S  = 7'(MAX_FALL);
  localparam logic [6:0]         GRAVITY7    = 7'(GRAVITY);

  state_t             st;
  logic signed [5:0]  vel;
  logic               latched;
  logic               hit;
  logic signed [10:0] ny;
  logic signed [6:0]  vel_inc;
  logic signed [5:0]  vel_next;
  logic signed [10:0] scroll_d;
  logic [16:0]        score_sum;

  frame_contact_latch u_latch (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .contact    (contact),
    .latched    (latched)
  );

  assign state = st;
  assign hit   = latched | contact;

  // Candidate position, gravity-limited velocity and scroll amount for this tick.
  always_comb begin
    ny        = {1'b0, doodle_y} + {{5{vel[5]}}, vel};
    vel_inc   = {vel[5], vel} + GRAVITY7;
    vel_next  = (vel_inc > MAX_FALL_S) ? MAX_FALL_S[5:0] : vel_inc[5:0];
    scroll_d  = SCROLL_S - ny;
    score_sum = {1'b0, score} + {7'd0, scroll_d[9:0]};
  end

  // Game FSM and motion registers; everything advances only on the frame tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      vel       <= '0;
      doodle_y  <= START_Y10;
      v_counter <= '0;
      score     <= '0;
      game_over <= 1'b0;
    end else if (frame_tick) begin
      case (st)
        ST_IDLE: begin
          if (start) begin
            st  <= ST_RISING;
            vel <= LAUNCH_VEL;
          end
        end
        ST_RISING, ST_FALLING: begin
          if (st == ST_FALLING && hit) begin
            st  <= ST_RISING;
            vel <= LAUNCH_VEL;
          end else begin
            vel <= vel_next;
            if (st == ST_RISING) begin
              if (ny < SCROLL_S) begin
                doodle_y  <= SCROLL_Y10;
                v_counter <= v_counter + scroll_d[9:0];
                score     <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
              end else begin
                doodle_y <= ny[9:0];
              end
              if (!vel_next[5]) begin
                st <= ST_FALLING;
              end
            end else if (ny >= BOTTOM_S) begin
              doodle_y  <= BOTTOM_Y10;
              st        <= ST_DEAD;
              game_over <= 1'b1;
            end else begin
              doodle_y <= ny[9:0];
            end
          end
        end
        ST_DEAD: begin
          if (start) begin
            st        <= ST_IDLE;
            vel       <= '0;
            doodle_y  <= START_Y10;
            v_counter <= '0;
            score     <= '0;
            game_over <= 1'b0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_doodle_physics.sv
// tb/tb_doodle_physics.sv - randomized and directed checks of doodle_physics against a frame-level model
module tb_doodle_physics;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        start;
  logic        contact;
  logic [9:0]  doodle_y;
  logic [9:0]  v_counter;
  logic [15:0] score;
  logic        game_over;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  int m_y, m_vel, m_st, m_vc, m_score, m_go;
  bit m_latch;

  always #5 clk = ~clk;

  doodle_physics dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start      (start),
    .contact    (contact),
    .doodle_y   (doodle_y),
    .v_counter  (v_counter),
    .score      (score),
    .game_over  (game_over),
    .state      (state)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_y = 400; m_vel = 0; m_st = 0; m_vc = 0; m_score = 0; m_go = 0; m_latch = 0;
  endtask

  // One clock of the game rules, in whole-number arithmetic.
  task automatic model_step(input bit t, input bit s, input bit c, input bit r);
    int ny;
    int nv;
    int d;
    bit hit;
    if (r) begin
      model_reset();
    end else begin
      hit = m_latch || c;
      if (!t) begin
        if (c) m_latch = 1;
      end else begin
        m_latch = 0;
        if (m_st == 0) begin
          if (s) begin m_st = 1; m_vel = -12; end
        end else if (m_st == 3) begin
          if (s) model_reset();
        end else if (m_st == 2 && hit) begin
          m_st = 1; m_vel = -12;
        end else begin
          ny = m_y + m_vel;
          nv = (m_vel + 1 > 10) ? 10 : m_vel + 1;
          if (m_st == 1) begin
            if (ny < 200) begin
              d = 200 - ny;
              m_y = 200;
              m_vc = (m_vc + d) % 1024;
              m_score = (m_score + d > 65535) ? 65535 : m_score + d;
            end else begin
              m_y = ny;
            end
            if (nv >= 0) m_st = 2;
          end else if (ny >= 514) begin
            m_y = 514; m_st = 3; m_go = 1;
          end else begin
            m_y = ny;
          end
          m_vel = nv;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("doodle_y", int'(doodle_y), m_y);
    check("v_counter", int'(v_counter), m_vc);
    check("score", int'(score), m_score);
    check("game_over", int'(game_over), m_go);
    check("state", int'(state), m_st);
  endtask

  task automatic cycle(input bit t, input bit s, input bit c, input bit r);
    frame_tick = t; start = s; contact = c; rst = r;
    @(posedge clk);
    model_step(t, s, c, r);
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; contact = 1'b0;
    model_reset();
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("rst_y", int'(doodle_y), 400);
    check("rst_state", int'(state), 0);
    check("rst_score", int'(score), 0);

    // launch, then contact during the rise must not alter the trajectory
    cycle(1, 1, 0, 0);
    check("launch_state", int'(state), 1);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("first_rise_y", int'(doodle_y), 388);
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 11; i++) cycle(1, 0, 0, 0);
    check("apex_y", int'(doodle_y), 322);
    check("apex_state", int'(state), 2);

    // mid-frame contact while falling relaunches without moving
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("land_state", int'(state), 1);
    check("land_y", int'(doodle_y), 322);
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0);
    check("apex2_y", int'(doodle_y), 244);

    // contact on the tick itself, then climb past the scroll line
    cycle(1, 0, 1, 0);
    check("tick_land_state", int'(state), 1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    check("scroll_y", int'(doodle_y), 200);
    check("scroll_vc", int'(v_counter), 6);
    check("scroll_score", int'(score), 6);
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0);
    check("scroll_total", int'(score), 34);
    check("scroll_apex_state", int'(state), 2);

    // free fall to the bottom
    for (int i = 0; i < 300 && !game_over; i++) cycle(1, 0, 0, 0);
    check("dead_y", int'(doodle_y), 514);
    check("dead_go", int'(game_over), 1);
    check("dead_state", int'(state), 3);
    cycle(0, 1, 0, 0);
    check("dead_no_tick", int'(state), 3);
    cycle(1, 1, 0, 0);
    check("restart_state", int'(state), 0);
    check("restart_y", int'(doodle_y), 400);
    check("restart_score", int'(score), 0);

    // reset wins over tick, start and contact
    cycle(1, 1, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 1, 1, 1);
    check("rst_prio_state", int'(state), 0);
    check("rst_prio_y", int'(doodle_y), 400);
    cycle(1, 0, 0, 0);
    check("rst_idle_hold", int'(state), 0);

    // endless bouncing: v_counter wraps many times and score saturates
    cycle(1, 1, 1, 0);
    for (int i = 0; i < 12000; i++) begin
      cycle(0, 0, 1, 0);
      cycle(1, 0, 1, 0);
    end
    check("score_sat", int'(score), 65535);

    // randomized play
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(2) == 0), ($urandom_range(7) == 0),
            ($urandom_range(5) == 0), ($urandom_range(499) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
